// File: rtl/wordle_pkg.sv
// Shared encodings for the Wordle game controller: FSM states, per-letter
// feedback codes and the ASCII bounds used for letter validation.
package wordle_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_SCORE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] FB_NONE = 2'b00;
  localparam logic [1:0] FB_GREY = 2'b01;
  localparam logic [1:0] FB_YEL  = 2'b10;
  localparam logic [1:0] FB_GRN  = 2'b11;

  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UZ = 8'h5A;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LZ = 8'h7A;
  localparam logic [7:0] CASE_OFS = 8'h20;

endpackage

// File: rtl/wordle_scorer.sv
// Sequential guess scorer: one green pass, then one yellow/grey decision per
// letter, claiming the lowest unused matching secret slot for duplicates.
module wordle_scorer
  import wordle_pkg::*;
#(
  parameter int unsigned WORD_LEN = 5,
  parameter int unsigned CHAR_W   = 8
) (
  input  logic                       Clk,
  input  logic                       reset_n,
  input  logic                       i_start,
  input  logic [WORD_LEN*CHAR_W-1:0] i_guess,
  input  logic [WORD_LEN*CHAR_W-1:0] i_secret,
  output logic [2*WORD_LEN-1:0]      o_feedback,
  output logic                       o_done
);

  localparam int unsigned   PW       = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [PW-1:0] LAST_POS = PW'(WORD_LEN - 1);

  logic [1:0]          r_fb [WORD_LEN];
  logic [WORD_LEN-1:0] r_used;
  logic [PW-1:0]       r_pos;
  logic                r_busy;

  logic [1:0]          w_grn_fb [WORD_LEN];
  logic [WORD_LEN-1:0] w_grn_used;
  logic [1:0]          w_fb_nxt [WORD_LEN];
  logic [WORD_LEN-1:0] w_used_nxt;
  logic                w_found;

  function automatic logic [CHAR_W-1:0] letter_at(input logic [WORD_LEN*CHAR_W-1:0] w,
                                                  input int unsigned j);
    return w[(WORD_LEN-1-j)*CHAR_W +: CHAR_W];
  endfunction

  always_comb begin
    w_grn_used = '0;
    for (int unsigned j = 0; j < WORD_LEN; j++) begin
      w_grn_fb[j] = FB_NONE;
      if (letter_at(i_guess, j) == letter_at(i_secret, j)) begin
        w_grn_fb[j]   = FB_GRN;
        w_grn_used[j] = 1'b1;
      end
    end
  end

  // The current yellow decision is exposed combinationally so the final
  // position is visible in the same cycle o_done is asserted.
  always_comb begin
    w_fb_nxt   = r_fb;
    w_used_nxt = r_used;
    w_found    = 1'b0;
    for (int unsigned j = 0; j < WORD_LEN; j++) begin
      if (r_busy && (PW'(j) == r_pos) && (r_fb[j] != FB_GRN)) begin
        for (int unsigned k = 0; k < WORD_LEN; k++) begin
          if (!w_found && !r_used[k] && (letter_at(i_secret, k) == letter_at(i_guess, j))) begin
            w_found       = 1'b1;
            w_used_nxt[k] = 1'b1;
          end
        end
        w_fb_nxt[j] = w_found ? FB_YEL : FB_GREY;
      end
    end
  end

  always_comb begin
    o_feedback = '0;
    for (int unsigned j = 0; j < WORD_LEN; j++) begin
      o_feedback[(WORD_LEN-1-j)*2 +: 2] = w_fb_nxt[j];
    end
  end

  assign o_done = r_busy && (r_pos == LAST_POS);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned j = 0; j < WORD_LEN; j++) begin
        r_fb[j] <= FB_NONE;
      end
      r_used <= '0;
      r_pos  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_fb   <= w_grn_fb;
      r_used <= w_grn_used;
      r_pos  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_fb   <= w_fb_nxt;
      r_used <= w_used_nxt;
      if (r_pos == LAST_POS) begin
        r_busy <= 1'b0;
      end else begin
        r_pos <= r_pos + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wordle_game_ctrl.sv
// Wordle game controller: letter entry with backspace, auto-submit to the
// scorer, guess counting and win/lose result held until acknowledged.
module wordle_game_ctrl
  import wordle_pkg::*;
#(
  parameter int unsigned WORD_LEN    = 5,
  parameter int unsigned MAX_GUESSES = 6,
  parameter int unsigned CHAR_W      = 8
) (
  input  logic                                 Clk,
  input  logic                                 reset_n,
  input  logic                                 Start,
  input  logic                                 Ack,
  input  logic                                 C,
  input  logic                                 Bksp,
  input  logic [CHAR_W-1:0]                    curr_letter,
  input  logic [WORD_LEN*CHAR_W-1:0]           secretWord,
  output logic [WORD_LEN*CHAR_W-1:0]           guessWord,
  output logic [$clog2(WORD_LEN+1)-1:0]        I,
  output logic [$clog2(MAX_GUESSES+1)-1:0]     guess_cnt,
  output logic [2*WORD_LEN-1:0]                feedback,
  output logic                                 fb_valid,
  output logic                                 q_I,
  output logic                                 q_Entry,
  output logic                                 q_Score,
  output logic                                 q_Done,
  output logic                                 win,
  output logic                                 lose
);

  localparam int unsigned   IW       = $clog2(WORD_LEN + 1);
  localparam int unsigned   GW       = $clog2(MAX_GUESSES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_LEN - 1);
  localparam logic [GW-1:0] LAST_GC  = GW'(MAX_GUESSES - 1);

  state_t                     r_state;
  logic [CHAR_W-1:0]          r_letters [WORD_LEN];
  logic [IW-1:0]              r_idx;
  logic [GW-1:0]              r_gcnt;
  logic [2*WORD_LEN-1:0]      r_feedback;
  logic                       r_fb_valid;
  logic                       r_win;
  logic                       r_lose;
  logic                       r_score_start;

  logic                       w_is_upper;
  logic                       w_is_lower;
  logic                       w_letter_ok;
  logic [CHAR_W-1:0]          w_letter_uc;
  logic [WORD_LEN*CHAR_W-1:0] w_guess;
  logic [2*WORD_LEN-1:0]      w_sc_fb;
  logic                       w_sc_done;
  logic                       w_all_grn;

  always_comb begin
    w_is_upper  = (curr_letter >= CHAR_W'(ASCII_UA)) && (curr_letter <= CHAR_W'(ASCII_UZ));
    w_is_lower  = (curr_letter >= CHAR_W'(ASCII_LA)) && (curr_letter <= CHAR_W'(ASCII_LZ));
    w_letter_ok = w_is_upper || w_is_lower;
    w_letter_uc = w_is_lower ? (curr_letter - CHAR_W'(CASE_OFS)) : curr_letter;
  end

  always_comb begin
    w_guess = '0;
    for (int unsigned j = 0; j < WORD_LEN; j++) begin
      w_guess[(WORD_LEN-1-j)*CHAR_W +: CHAR_W] = r_letters[j];
    end
  end

  assign w_all_grn = (w_sc_fb == {WORD_LEN{FB_GRN}});

  wordle_scorer #(
    .WORD_LEN (WORD_LEN),
    .CHAR_W   (CHAR_W)
  ) u_scorer (
    .Clk        (Clk),
    .reset_n    (reset_n),
    .i_start    (r_score_start),
    .i_guess    (w_guess),
    .i_secret   (secretWord),
    .o_feedback (w_sc_fb),
    .o_done     (w_sc_done)
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_INIT;
      for (int unsigned j = 0; j < WORD_LEN; j++) begin
        r_letters[j] <= '0;
      end
      r_idx         <= '0;
      r_gcnt        <= '0;
      r_feedback    <= '0;
      r_fb_valid    <= 1'b0;
      r_win         <= 1'b0;
      r_lose        <= 1'b0;
      r_score_start <= 1'b0;
    end else begin
      r_score_start <= 1'b0;
      case (r_state)
        ST_INIT: begin
          for (int unsigned j = 0; j < WORD_LEN; j++) begin
            r_letters[j] <= '0;
          end
          r_idx      <= '0;
          r_gcnt     <= '0;
          r_feedback <= '0;
          r_fb_valid <= 1'b0;
          r_win      <= 1'b0;
          r_lose     <= 1'b0;
          if (Start) begin
            r_state <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (Bksp) begin
            if (r_idx != '0) begin
              r_idx <= r_idx - 1'b1;
              for (int unsigned j = 0; j < WORD_LEN; j++) begin
                if (IW'(j + 1) == r_idx) begin
                  r_letters[j] <= '0;
                end
              end
            end
          end else if (C && w_letter_ok) begin
            for (int unsigned j = 0; j < WORD_LEN; j++) begin
              if (IW'(j) == r_idx) begin
                r_letters[j] <= w_letter_uc;
              end
            end
            r_idx <= r_idx + 1'b1;
            if (r_idx == '0) begin
              r_fb_valid <= 1'b0;
              r_feedback <= '0;
            end
            if (r_idx == LAST_IDX) begin
              r_state       <= ST_SCORE;
              r_score_start <= 1'b1;
            end
          end
        end
        ST_SCORE: begin
          if (w_sc_done) begin
            r_feedback <= w_sc_fb;
            r_fb_valid <= 1'b1;
            r_gcnt     <= r_gcnt + 1'b1;
            if (w_all_grn) begin
              r_win   <= 1'b1;
              r_state <= ST_DONE;
            end else if (r_gcnt == LAST_GC) begin
              r_lose  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_idx <= '0;
              for (int unsigned j = 0; j < WORD_LEN; j++) begin
                r_letters[j] <= '0;
              end
              r_state <= ST_ENTRY;
            end
          end
        end
        ST_DONE: begin
          if (Ack) begin
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
            r_state <= ST_INIT;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign guessWord = w_guess;
  assign I         = r_idx;
  assign guess_cnt = r_gcnt;
  assign feedback  = r_feedback;
  assign fb_valid  = r_fb_valid;
  assign win       = r_win;
  assign lose      = r_lose;
  assign q_I       = (r_state == ST_INIT);
  assign q_Entry   = (r_state == ST_ENTRY);
  assign q_Score   = (r_state == ST_SCORE);
  assign q_Done    = (r_state == ST_DONE);

endmodule
